// File: rtl/decode_pkg.sv
// Shared decode definitions for decode_stage_p: opcode/funct constants, PCSrc encoding,
// control enums and the instruction-class decoder.
package decode_pkg;

  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;
  localparam logic [5:0] OP_ORI    = 6'h0D;
  localparam logic [5:0] OP_LUI    = 6'h0F;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_SW     = 6'h2B;

  localparam logic [5:0] FN_JR     = 6'h08;
  localparam logic [5:0] FN_ADDU   = 6'h21;
  localparam logic [5:0] FN_SUBU   = 6'h23;

  localparam logic [4:0] RT_BLTZ   = 5'd0;
  localparam logic [4:0] RT_BGEZ   = 5'd1;

  localparam logic [1:0] PCSRC_SEQ = 2'b00;
  localparam logic [1:0] PCSRC_NPC = 2'b01;
  localparam logic [1:0] PCSRC_JR  = 2'b10;

  typedef enum logic [1:0] {EXT_ZERO, EXT_SIGN, EXT_LUI} ext_e;
  typedef enum logic [1:0] {SRC_NONE, SRC_RS, SRC_RS_RT} src_e;
  typedef enum logic [1:0] {DST_NONE, DST_RD, DST_RT, DST_LINK} dst_e;

  typedef enum logic [3:0] {
    I_NOP, I_ADDU, I_SUBU, I_ORI, I_LUI, I_LW, I_SW, I_BEQ,
    I_BNE, I_BLEZ, I_BGTZ, I_BLTZ, I_BGEZ, I_J, I_JAL, I_JR
  } instr_e;

  typedef struct packed {
    instr_e kind;
    src_e   src;
    dst_e   dst;
    ext_e   ext;
  } ctrl_t;

  // Unrecognised encodings fall through to the nop default.
  function automatic ctrl_t decode(input logic [31:0] instr);
    ctrl_t c;
    c = '{I_NOP, SRC_NONE, DST_NONE, EXT_SIGN};
    case (instr[31:26])
      OP_RTYPE: begin
        case (instr[5:0])
          FN_ADDU: c = '{I_ADDU, SRC_RS_RT, DST_RD, EXT_SIGN};
          FN_SUBU: c = '{I_SUBU, SRC_RS_RT, DST_RD, EXT_SIGN};
          FN_JR:   c = '{I_JR, SRC_RS, DST_NONE, EXT_SIGN};
          default: ;
        endcase
      end
      OP_REGIMM: begin
        if (instr[20:16] == RT_BLTZ)      c = '{I_BLTZ, SRC_RS, DST_NONE, EXT_SIGN};
        else if (instr[20:16] == RT_BGEZ) c = '{I_BGEZ, SRC_RS, DST_NONE, EXT_SIGN};
      end
      OP_J:    c = '{I_J, SRC_NONE, DST_NONE, EXT_SIGN};
      OP_JAL:  c = '{I_JAL, SRC_NONE, DST_LINK, EXT_SIGN};
      OP_BEQ:  c = '{I_BEQ, SRC_RS_RT, DST_NONE, EXT_SIGN};
      OP_BNE:  c = '{I_BNE, SRC_RS_RT, DST_NONE, EXT_SIGN};
      OP_BLEZ: c = '{I_BLEZ, SRC_RS, DST_NONE, EXT_SIGN};
      OP_BGTZ: c = '{I_BGTZ, SRC_RS, DST_NONE, EXT_SIGN};
      OP_ORI:  c = '{I_ORI, SRC_RS, DST_RT, EXT_ZERO};
      OP_LUI:  c = '{I_LUI, SRC_NONE, DST_RT, EXT_LUI};
      OP_LW:   c = '{I_LW, SRC_RS, DST_RT, EXT_SIGN};
      OP_SW:   c = '{I_SW, SRC_RS_RT, DST_NONE, EXT_SIGN};
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/decode_stage_p_if.sv
// Pipeline-side bundle of decode_stage_p: F-stage inputs, E/M/W forward inputs, D outputs.
interface decode_stage_p_if #(
  parameter int XLEN = 32,
  parameter int NREG = 32
);
  localparam int AW = $clog2(NREG);

  logic [31:0]     InstrF;
  logic [XLEN-1:0] PC4F;
  logic            Flush;
  logic [31:0]     InstrD;
  logic [XLEN-1:0] PC4D;
  logic [AW-1:0]   A3E, A3M;
  logic [XLEN-1:0] WDE, WDM;
  logic            ReadyE, ReadyM;
  logic            RegWriteW;
  logic [AW-1:0]   A3W;
  logic [XLEN-1:0] WDW;
  logic [XLEN-1:0] RD1DE, RD2DE, Imm32DE, WDDE, NPCOut;
  logic [AW-1:0]   A3DE;
  logic            StallD;
  logic [1:0]      PCSrc;

  // Handshake: ReadyE/ReadyM mark WDE/WDM valid in the current cycle; StallD is the only
  // back-pressure and is driven from them combinationally, never the other way round.
  modport master (
    output InstrF, PC4F, Flush, A3E, A3M, WDE, WDM, ReadyE, ReadyM, RegWriteW, A3W, WDW,
    input  InstrD, PC4D, RD1DE, RD2DE, Imm32DE, A3DE, WDDE, StallD, PCSrc, NPCOut
  );
  modport slave (
    input  InstrF, PC4F, Flush, A3E, A3M, WDE, WDM, ReadyE, ReadyM, RegWriteW, A3W, WDW,
    output InstrD, PC4D, RD1DE, RD2DE, Imm32DE, A3DE, WDDE, StallD, PCSrc, NPCOut
  );
endinterface

// File: rtl/decode_stage_p_gpr_file.sv
// Register file, two read / one write port, register 0 hardwired to zero.
// Define GRF_BYPASS_EN to make a same-cycle write visible on the read ports.
module gpr_file #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  localparam int AW = $clog2(NREG)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [AW-1:0]   ra1_i,
  input  logic [AW-1:0]   ra2_i,
  output logic [XLEN-1:0] rd1_o,
  output logic [XLEN-1:0] rd2_o,
  input  logic            we_i,
  input  logic [AW-1:0]   wa_i,
  input  logic [XLEN-1:0] wd_i
);

  logic [XLEN-1:0] regs_q [NREG];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (we_i && (wa_i != '0)) begin
      regs_q[wa_i] <= wd_i;
    end
  end

`ifdef GRF_BYPASS_EN
  assign rd1_o = (ra1_i == '0) ? '0 : (we_i && (wa_i == ra1_i)) ? wd_i : regs_q[ra1_i];
  assign rd2_o = (ra2_i == '0) ? '0 : (we_i && (wa_i == ra2_i)) ? wd_i : regs_q[ra2_i];
`else
  assign rd1_o = (ra1_i == '0) ? '0 : regs_q[ra1_i];
  assign rd2_o = (ra2_i == '0) ? '0 : regs_q[ra2_i];
`endif

endmodule

// File: rtl/decode_stage_p.sv
// MIPS decode stage: IF/ID register, register file, E/M forwarding, load-use stall and
// branch/jump resolution. GRF_BYPASS_EN (see gpr_file) selects same-cycle W bypass.
module decode_stage_p
  import decode_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input logic Clk,
  input logic Reset,
  decode_stage_p_if.slave bus
);

  localparam int AW = $clog2(NREG);

  logic [31:0]     instr_d, instr_q;
  logic [XLEN-1:0] pc4_d, pc4_q;
  logic            stall;

  always_comb begin
    instr_d = instr_q;
    pc4_d   = pc4_q;
    if (bus.Flush) begin
      instr_d = '0;
      pc4_d   = '0;
    end else if (!stall) begin
      instr_d = bus.InstrF;
      pc4_d   = bus.PC4F;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      instr_q <= '0;
      pc4_q   <= '0;
    end else begin
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
    end
  end

  logic [AW-1:0]   rs_a, rt_a, rd_a;
  logic [15:0]     imm16;
  logic [25:0]     imm26;
  ctrl_t           ctrl;
  logic [XLEN-1:0] rf_rd1, rf_rd2, rs_val, rt_val;

  assign rs_a  = instr_q[21 +: AW];
  assign rt_a  = instr_q[16 +: AW];
  assign rd_a  = instr_q[11 +: AW];
  assign imm16 = instr_q[15:0];
  assign imm26 = instr_q[25:0];
  assign ctrl  = decode(instr_q);

  gpr_file #(.XLEN(XLEN), .NREG(NREG)) u_gpr (
    .clk_i  (Clk),
    .rst_ni (Reset),
    .ra1_i  (rs_a),
    .ra2_i  (rt_a),
    .rd1_o  (rf_rd1),
    .rd2_o  (rf_rd2),
    .we_i   (bus.RegWriteW),
    .wa_i   (bus.A3W),
    .wd_i   (bus.WDW)
  );

  // E has priority over M; a zero address never matches since A3E/A3M=0 means no write.
  always_comb begin
    if (rs_a == '0)            rs_val = '0;
    else if (rs_a == bus.A3E)  rs_val = bus.WDE;
    else if (rs_a == bus.A3M)  rs_val = bus.WDM;
    else                       rs_val = rf_rd1;
    if (rt_a == '0)            rt_val = '0;
    else if (rt_a == bus.A3E)  rt_val = bus.WDE;
    else if (rt_a == bus.A3M)  rt_val = bus.WDM;
    else                       rt_val = rf_rd2;
  end

  function automatic logic waits(input logic [AW-1:0] a, input logic [AW-1:0] a3e,
                                 input logic rdy_e, input logic [AW-1:0] a3m, input logic rdy_m);
    return (a != '0) && ((a == a3e) ? !rdy_e : ((a == a3m) && !rdy_m));
  endfunction

  assign stall = ((ctrl.src != SRC_NONE) && waits(rs_a, bus.A3E, bus.ReadyE, bus.A3M, bus.ReadyM)) ||
                 ((ctrl.src == SRC_RS_RT) && waits(rt_a, bus.A3E, bus.ReadyE, bus.A3M, bus.ReadyM));

  logic taken, rs_neg, rs_zero;
  assign rs_neg  = rs_val[XLEN-1];
  assign rs_zero = (rs_val == '0);

  always_comb begin
    case (ctrl.kind)
      I_BEQ:   taken = (rs_val == rt_val);
      I_BNE:   taken = (rs_val != rt_val);
      I_BLEZ:  taken = rs_neg || rs_zero;
      I_BGTZ:  taken = !rs_neg && !rs_zero;
      I_BLTZ:  taken = rs_neg;
      I_BGEZ:  taken = !rs_neg;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    bus.PCSrc  = PCSRC_SEQ;
    bus.NPCOut = pc4_q;
    bus.A3DE   = '0;
    if (!stall) begin
      if (taken) begin
        bus.PCSrc  = PCSRC_NPC;
        bus.NPCOut = pc4_q + XLEN'(signed'({imm16, 2'b00}));
      end else if ((ctrl.kind == I_J) || (ctrl.kind == I_JAL)) begin
        bus.PCSrc  = PCSRC_NPC;
        bus.NPCOut = {pc4_q[XLEN-1:28], imm26, 2'b00};
      end else if (ctrl.kind == I_JR) begin
        bus.PCSrc  = PCSRC_JR;
        bus.NPCOut = rs_val;
      end
      case (ctrl.dst)
        DST_RD:   bus.A3DE = rd_a;
        DST_RT:   bus.A3DE = rt_a;
        DST_LINK: bus.A3DE = AW'(NREG - 1);
        default:  ;
      endcase
    end
  end

  always_comb begin
    case (ctrl.ext)
      EXT_ZERO: bus.Imm32DE = XLEN'(imm16);
      EXT_LUI:  bus.Imm32DE = XLEN'(signed'({imm16, 16'h0000}));
      default:  bus.Imm32DE = XLEN'(signed'(imm16));
    endcase
  end

  assign bus.InstrD = instr_q;
  assign bus.PC4D   = pc4_q;
  assign bus.RD1DE  = rs_val;
  assign bus.RD2DE  = rt_val;
  assign bus.WDDE   = pc4_q + XLEN'(4);
  assign bus.StallD = stall;

endmodule

// File: tb/tb_decode_stage_p.sv
// Directed bench for decode_stage_p (NREG=16) with a mnemonic-level reference model.
module tb_decode_stage_p;

  localparam int XLEN = 32;
  localparam int NREG = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  decode_stage_p_if #(.XLEN(XLEN), .NREG(NREG)) bus();

  decode_stage_p #(.XLEN(XLEN), .NREG(NREG)) dut (
    .Clk   (clk),
    .Reset (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_next(input string name, input logic [31:0] act);
    if (exp_q.size() == 0) check({name, " (no expectation queued)"}, act, ~act);
    else check(name, act, exp_q.pop_front());
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_instr = '0;
  logic [31:0] m_pc4 = '0;
  logic [31:0] m_rf [NREG];
  bit          m_stall = 1'b0;

  function automatic string mnem(input logic [31:0] ins);
    case (ins[31:26])
      6'h00: begin
        if (ins[5:0] == 6'h21) return "addu";
        if (ins[5:0] == 6'h23) return "subu";
        if (ins[5:0] == 6'h08) return "jr";
        return "nop";
      end
      6'h01: begin
        if (ins[20:16] == 5'd0) return "bltz";
        if (ins[20:16] == 5'd1) return "bgez";
        return "nop";
      end
      6'h02: return "j";
      6'h03: return "jal";
      6'h04: return "beq";
      6'h05: return "bne";
      6'h06: return "blez";
      6'h07: return "bgtz";
      6'h0D: return "ori";
      6'h0F: return "lui";
      6'h23: return "lw";
      6'h2B: return "sw";
      default: return "nop";
    endcase
  endfunction

  function automatic logic [31:0] opnd(input int a);
    if (a == 0) return 32'h0;
    if (a == int'(bus.A3E)) return bus.WDE;
    if (a == int'(bus.A3M)) return bus.WDM;
`ifdef GRF_BYPASS_EN
    if (bus.RegWriteW && (a == int'(bus.A3W))) return bus.WDW;
`endif
    return m_rf[a];
  endfunction

  function automatic bit blocked(input int a);
    if (a == 0) return 1'b0;
    if (a == int'(bus.A3E)) return !bus.ReadyE;
    return (a == int'(bus.A3M)) && !bus.ReadyM;
  endfunction

  always @(negedge clk) begin
    string mn;
    int rs, rt, rd, a3;
    bit reads_rs, reads_rt, stall, taken;
    logic [31:0] a, b, simm, imm, npc;
    logic [1:0] pcs;
    mn = mnem(m_instr);
    rs = int'(m_instr[25:21]) % NREG;
    rt = int'(m_instr[20:16]) % NREG;
    rd = int'(m_instr[15:11]) % NREG;
    simm = {{16{m_instr[15]}}, m_instr[15:0]};
    if (mn == "ori") imm = {16'h0, m_instr[15:0]};
    else if (mn == "lui") imm = {m_instr[15:0], 16'h0};
    else imm = simm;
    a = opnd(rs);
    b = opnd(rt);
    reads_rs = !(mn == "lui" || mn == "j" || mn == "jal" || mn == "nop");
    reads_rt = (mn == "addu" || mn == "subu" || mn == "sw" || mn == "beq" || mn == "bne");
    stall = (reads_rs && blocked(rs)) || (reads_rt && blocked(rt));
    taken = (mn == "beq" && a == b) || (mn == "bne" && a != b) ||
            (mn == "blez" && $signed(a) <= 0) || (mn == "bgtz" && $signed(a) > 0) ||
            (mn == "bltz" && $signed(a) < 0) || (mn == "bgez" && $signed(a) >= 0);
    pcs = 2'b00;
    npc = m_pc4;
    if (taken) begin pcs = 2'b01; npc = m_pc4 + (simm << 2); end
    else if (mn == "j" || mn == "jal") begin pcs = 2'b01; npc = {m_pc4[31:28], m_instr[25:0], 2'b00}; end
    else if (mn == "jr") begin pcs = 2'b10; npc = a; end
    if (mn == "addu" || mn == "subu") a3 = rd;
    else if (mn == "ori" || mn == "lui" || mn == "lw") a3 = rt;
    else if (mn == "jal") a3 = NREG - 1;
    else a3 = 0;
    if (stall) begin a3 = 0; pcs = 2'b00; end
    m_stall = stall;

    check("InstrD", bus.InstrD, m_instr);
    check("PC4D", bus.PC4D, m_pc4);
    check("StallD", 32'(bus.StallD), 32'(stall));
    check("A3DE", 32'(bus.A3DE), 32'(a3));
    check("PCSrc", 32'(bus.PCSrc), 32'(pcs));
    if (!stall) begin
      check("RD1DE", bus.RD1DE, a);
      check("RD2DE", bus.RD2DE, b);
      check("Imm32DE", bus.Imm32DE, imm);
      check("NPCOut", bus.NPCOut, npc);
      check("WDDE", bus.WDDE, m_pc4 + 32'd4);
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_instr = '0;
      m_pc4 = '0;
      for (int i = 0; i < NREG; i++) m_rf[i] = '0;
    end else begin
      if (bus.Flush) begin
        m_instr = '0;
        m_pc4 = '0;
      end else if (!m_stall) begin
        m_instr = bus.InstrF;
        m_pc4 = bus.PC4F;
      end
      if (bus.RegWriteW && bus.A3W != '0) m_rf[bus.A3W] = bus.WDW;
    end
  end

  // ---------------- driver ----------------
  function automatic logic [31:0] r_type(input int rs, input int rt, input int rd, input logic [5:0] fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
  endfunction
  function automatic logic [31:0] i_type(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic settle();
    @(negedge clk);
    #1;
  endtask
  task automatic wb(input int a, input logic [31:0] d);
    bus.RegWriteW = 1'b1;
    bus.A3W = 4'(a);
    bus.WDW = d;
    step();
  endtask

  logic [31:0] misc [8];

  initial begin
    for (int i = 0; i < NREG; i++) m_rf[i] = '0;
    bus.InstrF = '0; bus.PC4F = '0; bus.Flush = 1'b0;
    bus.A3E = '0; bus.A3M = '0; bus.WDE = '0; bus.WDM = '0;
    bus.ReadyE = 1'b1; bus.ReadyM = 1'b1;
    bus.RegWriteW = 1'b0; bus.A3W = '0; bus.WDW = '0;

    // Reset values
    settle();
    exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h4);
    expect_next("rst InstrD", bus.InstrD);
    expect_next("rst A3DE", 32'(bus.A3DE));
    expect_next("rst PCSrc", 32'(bus.PCSrc));
    expect_next("rst NPCOut", bus.NPCOut);
    expect_next("rst StallD", 32'(bus.StallD));
    expect_next("rst WDDE", bus.WDDE);
    step();
    rst_n = 1'b1;

    wb(1, 32'h11); wb(2, 32'h22); wb(6, 32'hFFFF_FFFF); wb(7, 32'h3040);
    bus.RegWriteW = 1'b0;

    // Forward priority: E over M, then M alone
    bus.InstrF = r_type(1, 2, 3, 6'h21); bus.PC4F = 32'h1004;
    step();
    bus.A3E = 4'd1; bus.WDE = 32'd5; bus.A3M = 4'd1; bus.WDM = 32'd9;
    settle();
    exp_q.push_back(32'd5); exp_q.push_back(32'h22); exp_q.push_back(32'd3);
    expect_next("fwd E RD1DE", bus.RD1DE);
    expect_next("fwd RD2DE", bus.RD2DE);
    expect_next("fwd A3DE", 32'(bus.A3DE));
    step();
    bus.A3E = '0;
    settle();
    exp_q.push_back(32'd9);
    expect_next("fwd M RD1DE", bus.RD1DE);
    step();
    bus.A3M = '0;

    // Load-use stall on beq $4,$0,+3
    bus.InstrF = i_type(6'h04, 4, 0, 16'd3); bus.PC4F = 32'h2004;
    step();
    bus.A3E = 4'd4; bus.ReadyE = 1'b0; bus.WDE = '0;
    bus.InstrF = i_type(6'h0D, 0, 8, 16'h1234); bus.PC4F = 32'h2008;
    settle();
    exp_q.push_back(32'd1); exp_q.push_back(32'd0); exp_q.push_back(32'd0);
    expect_next("lu StallD", 32'(bus.StallD));
    expect_next("lu A3DE", 32'(bus.A3DE));
    expect_next("lu PCSrc", 32'(bus.PCSrc));
    step();
    settle();
    exp_q.push_back(i_type(6'h04, 4, 0, 16'd3)); exp_q.push_back(32'h2004);
    expect_next("lu InstrD held", bus.InstrD);
    expect_next("lu PC4D held", bus.PC4D);
    step();
    bus.ReadyE = 1'b1;
    settle();
    exp_q.push_back(32'd0); exp_q.push_back(32'd1); exp_q.push_back(32'h2010);
    expect_next("lu resolved StallD", 32'(bus.StallD));
    expect_next("lu resolved PCSrc", 32'(bus.PCSrc));
    expect_next("lu resolved NPCOut", bus.NPCOut);
    step();
    bus.A3E = '0;
    settle();
    exp_q.push_back(32'h1234); exp_q.push_back(32'd8);
    expect_next("ori Imm32DE", bus.Imm32DE);
    expect_next("ori A3DE", 32'(bus.A3DE));

    // bltz, jr, jal
    bus.InstrF = i_type(6'h01, 6, 0, 16'hFFFF); bus.PC4F = 32'h3004;
    step(); settle();
    exp_q.push_back(32'd1); exp_q.push_back(32'h3000);
    expect_next("bltz PCSrc", 32'(bus.PCSrc));
    expect_next("bltz NPCOut", bus.NPCOut);
    bus.InstrF = r_type(7, 0, 0, 6'h08); bus.PC4F = 32'h3008;
    step(); settle();
    exp_q.push_back(32'd2); exp_q.push_back(32'h3040);
    expect_next("jr PCSrc", 32'(bus.PCSrc));
    expect_next("jr NPCOut", bus.NPCOut);
    bus.InstrF = {6'h03, 26'h0000C10}; bus.PC4F = 32'h3008;
    step(); settle();
    exp_q.push_back(32'd15); exp_q.push_back(32'h300C); exp_q.push_back(32'h3040);
    expect_next("jal A3DE", 32'(bus.A3DE));
    expect_next("jal WDDE", bus.WDDE);
    expect_next("jal NPCOut", bus.NPCOut);

    // Write to $0 is dropped; rs=17 truncates to $1
    bus.InstrF = r_type(17, 0, 9, 6'h21); bus.PC4F = 32'h3010;
    step();
    bus.RegWriteW = 1'b1; bus.A3W = '0; bus.WDW = 32'hDEAD;
    settle();
    exp_q.push_back(32'h11);
    expect_next("trunc RD1DE", bus.RD1DE);
    step();
    bus.RegWriteW = 1'b0;
    settle();
    exp_q.push_back(32'h0);
    expect_next("r0 RD2DE", bus.RD2DE);

    // Flush over stall
    bus.InstrF = i_type(6'h04, 4, 0, 16'd3); bus.PC4F = 32'h2004;
    step();
    bus.A3E = 4'd4; bus.ReadyE = 1'b0; bus.Flush = 1'b1;
    settle();
    exp_q.push_back(32'd1);
    expect_next("flush StallD", 32'(bus.StallD));
    step();
    bus.Flush = 1'b0; bus.A3E = '0; bus.ReadyE = 1'b1;
    settle();
    exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    expect_next("flush InstrD", bus.InstrD);
    expect_next("flush PC4D", bus.PC4D);

    // Same-cycle write-back read
    bus.InstrF = r_type(2, 0, 10, 6'h21); bus.PC4F = 32'h4004;
    step(); step();
    bus.RegWriteW = 1'b1; bus.A3W = 4'd2; bus.WDW = 32'd7;
    settle();
`ifdef GRF_BYPASS_EN
    exp_q.push_back(32'd7);
`else
    exp_q.push_back(32'h22);
`endif
    expect_next("bypass RD1DE", bus.RD1DE);
    step();
    bus.RegWriteW = 1'b0;
    settle();
    exp_q.push_back(32'd7);
    expect_next("after wb RD1DE", bus.RD1DE);

    // Immediate forms and remaining branches
    bus.InstrF = i_type(6'h0F, 0, 3, 16'h8001); bus.PC4F = 32'h5004;
    step(); settle();
    exp_q.push_back(32'h8001_0000); exp_q.push_back(32'd3);
    expect_next("lui Imm32DE", bus.Imm32DE);
    expect_next("lui A3DE", 32'(bus.A3DE));
    bus.InstrF = i_type(6'h2B, 1, 2, 16'hFFFC); bus.PC4F = 32'h5008;
    step(); settle();
    exp_q.push_back(32'hFFFF_FFFC); exp_q.push_back(32'd0);
    expect_next("sw Imm32DE", bus.Imm32DE);
    expect_next("sw A3DE", 32'(bus.A3DE));
    misc[0] = i_type(6'h01, 6, 1, 16'd4);
    misc[1] = i_type(6'h06, 0, 0, 16'd2);
    misc[2] = i_type(6'h07, 1, 0, 16'd1);
    misc[3] = r_type(2, 1, 5, 6'h23);
    misc[4] = {6'h02, 26'h0000100};
    misc[5] = i_type(6'h23, 7, 12, 16'd0);
    misc[6] = i_type(6'h05, 1, 2, 16'hFFFE);
    misc[7] = 32'hFC00_0000;
    for (int i = 0; i < 8; i++) begin
      bus.InstrF = misc[i];
      bus.PC4F = 32'h6004 + 32'(4 * i);
      step(); settle();
    end

    // Reset mid-run with addu presented
    bus.InstrF = r_type(1, 2, 3, 6'h21); bus.PC4F = 32'h7004;
    step();
    rst_n = 1'b0;
    settle();
    exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    expect_next("mid rst InstrD", bus.InstrD);
    expect_next("mid rst A3DE", 32'(bus.A3DE));
    expect_next("mid rst PCSrc", 32'(bus.PCSrc));
    step();
    rst_n = 1'b1;
    for (int i = 1; i < NREG; i++) begin
      bus.InstrF = r_type(i, i, 0, 6'h21);
      step(); settle();
      exp_q.push_back(32'h0);
      expect_next("post rst RD1DE", bus.RD1DE);
    end

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
